video_timing_gen: RTL and testbench

Programmable raster timing generator feeding the video freeze/sync-lock stage.
- Produces hs/vs/hbl/vbl in the polarity that stage consumes (blank active-high).
- Also produces data-enable, pixel coordinates and a frame-start strobe for the LCD renderer.
- Counters advance only on the pixel clock enable, so one system clock serves all pixel rates.

---
 rtl/video_timing_pkg.sv | 42 ++++
 rtl/video_timing_axis.sv | 88 ++++++++
 rtl/video_timing_gen.sv | 144 ++++++++++++++
 tb/tb_video_timing_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_pkg.sv
// ---------------------------------------------------------------------------
// video_timing_pkg
// Shared definitions for the raster timing generator:
//   - default 320x240 timing (per-axis active / front porch / sync / back porch)
//   - axis_timing_t : one axis worth of timing in pixels or lines
//   - axis_total()  : total period of one axis
//   - cnt_width()   : counter width able to hold 0 .. total-1
// ---------------------------------------------------------------------------
package video_timing_pkg;

   localparam int unsigned DEF_H_ACTIVE = 32'd320;
   localparam int unsigned DEF_H_FP     = 32'd16;
   localparam int unsigned DEF_H_SYNC   = 32'd32;
   localparam int unsigned DEF_H_BP     = 32'd32;
   localparam int unsigned DEF_V_ACTIVE = 32'd240;
   localparam int unsigned DEF_V_FP     = 32'd4;
   localparam int unsigned DEF_V_SYNC   = 32'd4;
   localparam int unsigned DEF_V_BP     = 32'd12;

   typedef struct packed {
      int unsigned active;
      int unsigned fp;
      int unsigned sync;
      int unsigned bp;
   } axis_timing_t;

   function automatic int unsigned axis_total(input axis_timing_t t);
      return t.active + t.fp + t.sync + t.bp;
   endfunction

   // A one-position axis still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned total);
      int unsigned w;
      if (total < 32'd2) begin
         w = 32'd1;
      end else begin
         w = $clog2(total);
      end
      return w;
   endfunction

endpackage

// File: rtl/video_timing_axis.sv
// ---------------------------------------------------------------------------
// video_timing_axis
// One raster axis: a position counter that advances on adv_i and wraps after
// the last position, plus blank/sync decode. Blank and sync are decoded from
// the *next* count and registered with it, so count, blank and sync always
// describe the same position.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   adv_i         : advance by one position this clock
//   wrap_o        : advancing from the last position this clock (combinational)
//   cnt_o         : registered position
//   blank_o       : registered blank, 1 when position >= active
//   sync_o        : registered sync, equal to POL inside the sync window
//   blank_nxt_o   : blank value that will be registered on this edge
// ---------------------------------------------------------------------------
module video_timing_axis
   import video_timing_pkg::*;
#(
   parameter axis_timing_t TIMING = '{active: DEF_H_ACTIVE, fp: DEF_H_FP,
                                      sync: DEF_H_SYNC, bp: DEF_H_BP},
   parameter bit           POL    = 1'b1,
   parameter int unsigned  W      = cnt_width(axis_total(TIMING))
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         adv_i,
   output logic         wrap_o,
   output logic [W-1:0] cnt_o,
   output logic         blank_o,
   output logic         sync_o,
   output logic         blank_nxt_o
);

   localparam int unsigned  TOTAL       = axis_total(TIMING);
   localparam logic [W-1:0] LAST        = W'(TOTAL - 32'd1);
   localparam logic [W-1:0] BLANK_START = W'(TIMING.active);
   localparam logic [W-1:0] SYNC_START  = W'(TIMING.active + TIMING.fp);
   localparam logic [W-1:0] SYNC_END    = W'(TIMING.active + TIMING.fp + TIMING.sync);

   logic [W-1:0] cnt_q, cnt_d;
   logic         blank_q, blank_d;
   logic         sync_q, sync_d;
   logic         at_last_s;

   // Next position: hold, step, or wrap to zero after the last position.
   always_comb begin
      at_last_s = (cnt_q == LAST);
      if (adv_i) begin
         if (at_last_s) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + W'(32'd1);
         end
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Blank/sync decode of the next position so they register in step with it.
   always_comb begin
      blank_d = (cnt_d >= BLANK_START);
      if ((cnt_d >= SYNC_START) && (cnt_d < SYNC_END)) begin
         sync_d = POL;
      end else begin
         sync_d = ~POL;
      end
   end

   // Position, blank and sync registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         blank_q <= 1'b0;
         sync_q  <= ~POL;
      end else begin
         cnt_q   <= cnt_d;
         blank_q <= blank_d;
         sync_q  <= sync_d;
      end
   end

   assign wrap_o      = adv_i & at_last_s;
   assign cnt_o       = cnt_q;
   assign blank_o     = blank_q;
   assign sync_o      = sync_q;
   assign blank_nxt_o = blank_d;

endmodule

// File: rtl/video_timing_gen.sv
// ---------------------------------------------------------------------------
// video_timing_gen
// Programmable raster timing generator. All counters advance only on ce_pix,
// so one system clock serves any pixel rate. Every output is registered and
// decoded from the next position, so all of them describe the same pixel.
// Ports:
//   clk, reset_n  : system clock, asynchronous active-low reset
//   ce_pix        : pixel clock enable (single-cycle pulses or held high)
//   hs, vs        : syncs, asserted level HS_POL / VS_POL
//   hbl, vbl      : blanks, 1 = blanking
//   de            : data enable, ~hbl & ~vbl
//   x, y          : pixel position
//   frame_start   : one-clk pulse when the position becomes (0,0)
//   frame_cnt     : 16-bit frame counter, only when VIDEO_TIMING_FRAME_CNT_EN
//                   is defined
// ---------------------------------------------------------------------------
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
   parameter int unsigned H_FP     = DEF_H_FP,
   parameter int unsigned H_SYNC   = DEF_H_SYNC,
   parameter int unsigned H_BP     = DEF_H_BP,
   parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
   parameter int unsigned V_FP     = DEF_V_FP,
   parameter int unsigned V_SYNC   = DEF_V_SYNC,
   parameter int unsigned V_BP     = DEF_V_BP,
   parameter bit          HS_POL   = 1'b1,
   parameter bit          VS_POL   = 1'b1,
   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int unsigned HW      = cnt_width(H_TOTAL),
   localparam int unsigned VW      = cnt_width(V_TOTAL)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          ce_pix,
   output logic          hs,
   output logic          vs,
   output logic          hbl,
   output logic          vbl,
   output logic          de,
   output logic [HW-1:0] x,
   output logic [VW-1:0] y,
   output logic          frame_start
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]   frame_cnt
`endif
);

   localparam axis_timing_t H_TIMING = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
   localparam axis_timing_t V_TIMING = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};

   if ((H_ACTIVE < 32'd1) || (H_FP < 32'd1) || (H_SYNC < 32'd1) || (H_BP < 32'd1) ||
       (V_ACTIVE < 32'd1) || (V_FP < 32'd1) || (V_SYNC < 32'd1) || (V_BP < 32'd1)) begin : g_param_err
      $error("video_timing_gen: every timing parameter must be at least 1");
   end
   if ((H_TOTAL < 32'd2) || (V_TOTAL < 32'd2)) begin : g_total_err
      $error("video_timing_gen: H_TOTAL and V_TOTAL must be at least 2");
   end

   logic h_wrap_s, v_wrap_s;
   logic hbl_nxt_s, vbl_nxt_s;
   logic de_q, de_d;
   logic frame_start_q, frame_start_d;

   video_timing_axis #(
      .TIMING (H_TIMING),
      .POL    (HS_POL),
      .W      (HW)
   ) u_h_axis (
      .clk         (clk),
      .reset_n     (reset_n),
      .adv_i       (ce_pix),
      .wrap_o      (h_wrap_s),
      .cnt_o       (x),
      .blank_o     (hbl),
      .sync_o      (hs),
      .blank_nxt_o (hbl_nxt_s)
   );

   // The vertical axis only steps on a line wrap, so vs/vbl never change mid-line.
   video_timing_axis #(
      .TIMING (V_TIMING),
      .POL    (VS_POL),
      .W      (VW)
   ) u_v_axis (
      .clk         (clk),
      .reset_n     (reset_n),
      .adv_i       (h_wrap_s),
      .wrap_o      (v_wrap_s),
      .cnt_o       (y),
      .blank_o     (vbl),
      .sync_o      (vs),
      .blank_nxt_o (vbl_nxt_s)
   );

   // Data enable and frame start from the next position; a frame wrap is the
   // only way to enter (0,0) by counting, so reset never produces a pulse.
   always_comb begin
      de_d          = ~hbl_nxt_s & ~vbl_nxt_s;
      frame_start_d = v_wrap_s;
   end

   // Data enable and frame start registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         de_q          <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         de_q          <= de_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign de          = de_q;
   assign frame_start = frame_start_q;

`ifdef VIDEO_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // Step on the same edge that raises frame_start; 16-bit add wraps to zero.
   always_comb begin
      if (frame_start_d) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
   end

   // Frame counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt_q <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_video_timing_gen
// Two instances share clock, reset and ce_pix: dut_def with the default
// 320x240 timing, and dut_sm with a tiny 15x8 raster and active-low syncs so
// whole frames fit in a short run.
//   dut_sm : H 8/2/3/2 (total 15), V 4/1/2/1 (total 8), frame = 120 pixels
// ---------------------------------------------------------------------------
module tb_video_timing_gen;

   localparam int unsigned SM_HT = 32'd15;
   localparam int unsigned SM_VT = 32'd8;
   localparam int unsigned SM_FRAME = SM_HT * SM_VT;

   logic clk = 1'b0;
   logic reset_n;
   logic ce_pix;

   always #5 clk = ~clk;

   logic       d_hs, d_vs, d_hbl, d_vbl, d_de, d_fs;
   logic [8:0] d_x, d_y;
   logic       s_hs, s_vs, s_hbl, s_vbl, s_de, s_fs;
   logic [3:0] s_x;
   logic [2:0] s_y;
`ifdef VIDEO_TIMING_FRAME_CNT_EN
   logic [15:0] d_fc, s_fc;
`endif

   video_timing_gen dut_def (
      .clk         (clk),
      .reset_n     (reset_n),
      .ce_pix      (ce_pix),
      .hs          (d_hs),
      .vs          (d_vs),
      .hbl         (d_hbl),
      .vbl         (d_vbl),
      .de          (d_de),
      .x           (d_x),
      .y           (d_y),
      .frame_start (d_fs)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt   (d_fc)
`endif
   );

   video_timing_gen #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (2), .V_BP (1),
      .HS_POL   (1'b0), .VS_POL (1'b0)
   ) dut_sm (
      .clk         (clk),
      .reset_n     (reset_n),
      .ce_pix      (ce_pix),
      .hs          (s_hs),
      .vs          (s_vs),
      .hbl         (s_hbl),
      .vbl         (s_vbl),
      .de          (s_de),
      .x           (s_x),
      .y           (s_y),
      .frame_start (s_fs)
`ifdef VIDEO_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt   (s_fc)
`endif
   );

   typedef struct {
      bit          sel;   // 0 = dut_def, 1 = dut_sm
      int unsigned p;     // pixel enables since reset
      int unsigned x;
      int unsigned y;
      bit hbl, vbl, hs, vs, de, fs;
   } vec_t;

   vec_t        vecs[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int unsigned cur;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic add(input bit sel, input int unsigned p, input int unsigned x, input int unsigned y,
                      input bit hbl, input bit vbl, input bit hs, input bit vs, input bit de, input bit fs);
      vec_t v;
      v.sel = sel; v.p = p; v.x = x; v.y = y;
      v.hbl = hbl; v.vbl = vbl; v.hs = hs; v.vs = vs; v.de = de; v.fs = fs;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ce_pix  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
      cur     = 0;
   endtask

   // One clock with the given enable; outputs are sampled 1 time unit after the edge.
   task automatic tick(input bit ce);
      ce_pix = ce;
      @(posedge clk);
      #1;
      ce_pix = 1'b0;
   endtask

   task automatic chk_vec(input int idx, input vec_t v);
      logic [31:0] ax, ay;
      logic        ahbl, avbl, ahs, avs, ade, afs;
      string       t;
      t    = $sformatf("vec%0d(p=%0d)", idx, v.p);
      ax   = v.sel ? 32'(s_x) : 32'(d_x);
      ay   = v.sel ? 32'(s_y) : 32'(d_y);
      ahbl = v.sel ? s_hbl : d_hbl;
      avbl = v.sel ? s_vbl : d_vbl;
      ahs  = v.sel ? s_hs  : d_hs;
      avs  = v.sel ? s_vs  : d_vs;
      ade  = v.sel ? s_de  : d_de;
      afs  = v.sel ? s_fs  : d_fs;
      chk({t, " x"},   ax, v.x);
      chk({t, " y"},   ay, v.y);
      chk({t, " hbl"}, 32'(ahbl), 32'(v.hbl));
      chk({t, " vbl"}, 32'(avbl), 32'(v.vbl));
      chk({t, " hs"},  32'(ahs),  32'(v.hs));
      chk({t, " vs"},  32'(avs),  32'(v.vs));
      chk({t, " de"},  32'(ade),  32'(v.de));
      chk({t, " fs"},  32'(afs),  32'(v.fs));
   endtask

   // Expected dut_sm outputs after p enables (active-low syncs).
   task automatic chk_sm_model(input string tag, input int unsigned p, input bit fs_exp);
      int unsigned mx, my;
      bit          ehbl, evbl;
      mx   = p % SM_HT;
      my   = (p / SM_HT) % SM_VT;
      ehbl = (mx >= 32'd8);
      evbl = (my >= 32'd4);
      chk({tag, " x"},   32'(s_x), mx);
      chk({tag, " y"},   32'(s_y), my);
      chk({tag, " hbl"}, 32'(s_hbl), 32'(ehbl));
      chk({tag, " vbl"}, 32'(s_vbl), 32'(evbl));
      chk({tag, " hs"},  32'(s_hs), ((mx >= 32'd10) && (mx < 32'd13)) ? 32'd0 : 32'd1);
      chk({tag, " vs"},  32'(s_vs), ((my >= 32'd5) && (my < 32'd7)) ? 32'd0 : 32'd1);
      chk({tag, " de"},  32'(s_de), 32'(!ehbl && !evbl));
      chk({tag, " fs"},  32'(s_fs), 32'(fs_exp));
   endtask

   initial begin
      int unsigned p;
      int          pulses;
      int          first_at;
      bit          ce_now;

      // ---- directed vectors: sel, p, x, y, hbl, vbl, hs, vs, de, fs ----
      add(1'b0,   0,   0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b0,   1,   1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b0, 319, 319, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b0, 320, 320, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 335, 335, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 336, 336, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 367, 367, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b0, 368, 368, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 399, 399, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b0, 400,   0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      add(1'b0, 720, 320, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      add(1'b1,   0,   0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      add(1'b1,   7,   7, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      add(1'b1,   8,   8, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1,  10,  10, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1,  12,  12, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      add(1'b1,  13,  13, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1,  14,  14, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1,  15,   0, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      add(1'b1,  59,  14, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1,  60,   0, 4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1,  74,  14, 4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1,  75,   0, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1,  82,   7, 5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 104,  14, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      add(1'b1, 105,   0, 7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1, 119,  14, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      add(1'b1, 120,   0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      add(1'b1, 121,   1, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      add(1'b1, 240,   0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

      // ---- table run with ce_pix held high ----
      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].p < cur) do_reset();
         while (cur < vecs[i].p) begin
            tick(1'b1);
            cur++;
         end
         chk_vec(i, vecs[i]);
      end

      // ---- ce_pix every 4th clock: holds between enables, pulse period 480 clks ----
      do_reset();
      p = 0; pulses = 0; first_at = 0;
      for (int c = 1; c <= 500; c++) begin
         ce_now = ((c % 4) == 0);
         tick(ce_now);
         if (ce_now) p++;
         chk_sm_model($sformatf("ce4 c%0d", c), p, ce_now && ((p % SM_FRAME) == 0));
         if (s_fs === 1'b1) begin
            pulses++;
            if (first_at == 0) first_at = c;
         end
      end
      chk("ce4 pulse count", pulses, 1);
      chk("ce4 first pulse clk", first_at, 480);

      // ---- ce_pix held low: everything frozen, no pulses ----
      for (int c = 0; c < 40; c++) begin
         tick(1'b0);
         chk_sm_model($sformatf("frozen c%0d", c), p, 1'b0);
      end

      // ---- asynchronous reset mid-frame (x=5, y=6 on dut_sm) ----
      do_reset();
      for (int c = 1; c <= 95; c++) begin
         tick(1'b1);
         chk_sm_model($sformatf("pre-rst p%0d", c), c, 1'b0);
      end
      #2;
      reset_n = 1'b0;
      #1;
      chk_sm_model("async rst sm", 0, 1'b0);
      chk("async rst def x",   32'(d_x), 32'd0);
      chk("async rst def y",   32'(d_y), 32'd0);
      chk("async rst def hbl", 32'(d_hbl), 32'd0);
      chk("async rst def vbl", 32'(d_vbl), 32'd0);
      chk("async rst def hs",  32'(d_hs), 32'd0);
      chk("async rst def vs",  32'(d_vs), 32'd0);
      chk("async rst def de",  32'(d_de), 32'd1);
      chk("async rst def fs",  32'(d_fs), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int c = 1; c <= 125; c++) begin
         tick(1'b1);
         chk_sm_model($sformatf("post-rst p%0d", c), c, (c % SM_FRAME) == 0);
      end

`ifdef VIDEO_TIMING_FRAME_CNT_EN
      // ---- frame counter wraps 0xFFFF -> 0x0000 on frame_start ----
      do_reset();
      chk("fcnt reset", 32'(s_fc), 32'd0);
      for (int c = 1; c <= 60; c++) tick(1'b1);
      force dut_sm.frame_cnt_q = 16'hFFFF;
      tick(1'b0);
      release dut_sm.frame_cnt_q;
      chk("fcnt preload", 32'(s_fc), 32'h0000FFFF);
      for (int c = 61; c <= 119; c++) tick(1'b1);
      chk("fcnt before wrap", 32'(s_fc), 32'h0000FFFF);
      tick(1'b1);
      chk("fcnt fs", 32'(s_fs), 32'd1);
      chk("fcnt wrapped", 32'(s_fc), 32'd0);
      tick(1'b1);
      chk("fcnt holds", 32'(s_fc), 32'd0);
      chk("fcnt def frames", 32'(d_fc), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
